fir_tap_axilite: RTL and testbench

FIR_TAP_AXILITE -- requirements
Module: fir_tap_axilite

---
 rtl/fir_tap_axilite.sv | 201 ++++++++++++++++++++
 tb/tb_fir_tap_axilite.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_tap_axilite.sv
// AXI-Lite register/tap-BRAM front end for the FIR core: ctrl, data_length and coefficient taps.
// Define FIR_TAP_WSTRB_EN to honour wstrb per byte; otherwise every write is whole-word.
module fir_tap_axilite #(
    parameter int NUM_TAPS = 11,
    parameter int ADDR_W   = 12
) (
    input  logic              axis_clk,
    input  logic              axis_rst,
    input  logic              awvalid,
    output logic              awready,
    input  logic [ADDR_W-1:0] awaddr,
    input  logic              wvalid,
    output logic              wready,
    input  logic [31:0]       wdata,
    input  logic [3:0]        wstrb,
    input  logic              arvalid,
    output logic              arready,
    input  logic [ADDR_W-1:0] araddr,
    output logic              rvalid,
    input  logic              rready,
    output logic [31:0]       rdata,
    output logic [3:0]        tap_WE,
    output logic              tap_EN,
    output logic [31:0]       tap_Di,
    output logic [ADDR_W-1:0] tap_A,
    input  logic [31:0]       tap_Do,
    input  logic [ADDR_W-1:0] core_tap_A,
    input  logic              core_busy,
    input  logic              core_done,
    output logic              ap_start_o,
    output logic [31:0]       data_length
);

    // Handshakes: a channel transfers on the rising edge where valid and ready are both 1;
    // the master holds valid/addr/data until then, and rdata is stable while rvalid waits on rready.

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR      = 3'd1,
        RD_ADDR = 3'd2,
        RD_WAIT = 3'd3,
        RD_RESP = 3'd4
    } state_t;

    localparam logic [ADDR_W-1:0] CTRL_ADDR = '0;
    localparam logic [ADDR_W-1:0] LEN_ADDR  = ADDR_W'(16);
    localparam logic [ADDR_W-1:0] TAP_LO    = ADDR_W'(32);
    localparam logic [ADDR_W-1:0] TAP_HI    = ADDR_W'(32 + 4 * NUM_TAPS);

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_blocked;
    logic [31:0]       rd_word;
    logic [3:0]        wr_strb;
    logic              ap_start;
    logic              ap_done;
    logic              ap_idle;

    function automatic logic is_tap(input logic [ADDR_W-1:0] a);
        return (a >= TAP_LO) && (a < TAP_HI) && (a[1:0] == 2'b00);
    endfunction

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[8*b +: 8] = strb[b] ? new_word[8*b +: 8] : old_word[8*b +: 8];
        end
        return res;
    endfunction

`ifdef FIR_TAP_WSTRB_EN
    assign wr_strb = wstrb;
`else
    logic unused_wstrb;
    assign unused_wstrb = ^wstrb;
    assign wr_strb      = 4'hF;
`endif

    assign ap_idle    = ~ap_start & ~core_busy;
    assign ap_start_o = ap_start;

    always_ff @(posedge axis_clk) begin
        if (axis_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        awready    = 1'b0;
        wready     = 1'b0;
        arready    = 1'b0;
        rvalid     = 1'b0;
        case (state)
            IDLE: begin
                if (awvalid && wvalid) begin
                    state_next = WR;
                end else if (arvalid) begin
                    state_next = RD_ADDR;
                end
            end
            WR: begin
                awready    = 1'b1;
                wready     = 1'b1;
                state_next = IDLE;
            end
            RD_ADDR: begin
                arready    = 1'b1;
                state_next = RD_WAIT;
            end
            RD_WAIT: begin
                state_next = RD_RESP;
            end
            RD_RESP: begin
                rvalid = 1'b1;
                if (rready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // The core owns the tap port while busy; AXI accesses are masked during reset so an
    // aborted write never reaches the BRAM.
    always_comb begin
        tap_EN = 1'b0;
        tap_WE = 4'h0;
        tap_A  = '0;
        tap_Di = '0;
        if (core_busy) begin
            tap_EN = 1'b1;
            tap_A  = core_tap_A;
        end else if (!axis_rst) begin
            if (state == WR && is_tap(awaddr)) begin
                tap_EN = 1'b1;
                tap_WE = wr_strb;
                tap_A  = awaddr - TAP_LO;
                tap_Di = wdata;
            end else if (state == RD_ADDR && is_tap(rd_addr)) begin
                tap_EN = 1'b1;
                tap_A  = rd_addr - TAP_LO;
            end
        end
    end

    always_comb begin
        rd_word = '0;
        if (rd_addr == CTRL_ADDR) begin
            rd_word = {29'd0, ap_idle, ap_done, ap_start};
        end else if (rd_addr == LEN_ADDR) begin
            rd_word = data_length;
        end else if (is_tap(rd_addr)) begin
            rd_word = rd_blocked ? 32'hFFFF_FFFF : tap_Do;
        end
    end

    // The read address is captured on entry to RD_ADDR so tap_A is register-driven there.
    always_ff @(posedge axis_clk) begin
        if (axis_rst) begin
            rd_addr     <= '0;
            rd_blocked  <= 1'b0;
            rdata       <= '0;
            data_length <= '0;
            ap_start    <= 1'b0;
            ap_done     <= 1'b0;
        end else begin
            if (state == IDLE && !(awvalid && wvalid) && arvalid) begin
                rd_addr <= araddr;
            end
            if (state == RD_ADDR) begin
                rd_blocked <= core_busy;
            end
            if (state == RD_WAIT) begin
                rdata <= rd_word;
            end
            if (state == WR && awaddr == LEN_ADDR && !core_busy) begin
                data_length <= merge_bytes(data_length, wdata, wr_strb);
            end
            if (core_busy) begin
                ap_start <= 1'b0;
            end else if (state == WR && awaddr == CTRL_ADDR && wr_strb[0] && wdata[0] && ap_idle) begin
                ap_start <= 1'b1;
            end
            // A done pulse coinciding with the clearing read must not be lost.
            if (core_done) begin
                ap_done <= 1'b1;
            end else if (state == RD_RESP && rready && rd_addr == CTRL_ADDR) begin
                ap_done <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fir_tap_axilite.sv
// Directed bench for fir_tap_axilite: BRAM model, register/tap scoreboard, per-cycle compare.
// Build with or without FIR_TAP_WSTRB_EN; strobe expectations follow the macro.
module tb_fir_tap_axilite;

    localparam int NUM_TAPS = 11;
    localparam int ADDR_W   = 12;

    logic              clk;
    logic              axis_rst;
    logic              awvalid, wvalid, arvalid, rready;
    logic              awready, wready, arready, rvalid;
    logic [ADDR_W-1:0] awaddr, araddr;
    logic [31:0]       wdata, rdata;
    logic [3:0]        wstrb;
    logic [3:0]        tap_WE;
    logic              tap_EN;
    logic [31:0]       tap_Di, tap_Do;
    logic [ADDR_W-1:0] tap_A, core_tap_A;
    logic              core_busy, core_done;
    logic              ap_start_o;
    logic [31:0]       data_length;

    fir_tap_axilite #(.NUM_TAPS(NUM_TAPS), .ADDR_W(ADDR_W)) dut (
        .axis_clk    (clk),
        .axis_rst    (axis_rst),
        .awvalid     (awvalid),
        .awready     (awready),
        .awaddr      (awaddr),
        .wvalid      (wvalid),
        .wready      (wready),
        .wdata       (wdata),
        .wstrb       (wstrb),
        .arvalid     (arvalid),
        .arready     (arready),
        .araddr      (araddr),
        .rvalid      (rvalid),
        .rready      (rready),
        .rdata       (rdata),
        .tap_WE      (tap_WE),
        .tap_EN      (tap_EN),
        .tap_Di      (tap_Di),
        .tap_A       (tap_A),
        .tap_Do      (tap_Do),
        .core_tap_A  (core_tap_A),
        .core_busy   (core_busy),
        .core_done   (core_done),
        .ap_start_o  (ap_start_o),
        .data_length (data_length)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded its time budget");
        $fatal(1, "timeout");
    end

    // ---------------- tap BRAM (1-cycle read latency) ----------------
    logic [31:0] bram [NUM_TAPS];
    always @(posedge clk) begin : bram_blk
        int idx;
        idx = int'(tap_A) / 4;
        if (tap_EN && idx < NUM_TAPS) begin
            tap_Do <= bram[idx];
            for (int b = 0; b < 4; b++) begin
                if (tap_WE[b]) bram[idx][8*b +: 8] <= tap_Di[8*b +: 8];
            end
        end
    end

    // ---------------- scoreboard / model ----------------
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mdl_tap [NUM_TAPS];
    logic [31:0] mdl_len;
    logic        mdl_start;
    logic        mdl_done;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    function automatic bit is_tap_addr(input logic [ADDR_W-1:0] a);
        int ai;
        ai = int'(a);
        return (ai >= 32) && (ai < 32 + 4 * NUM_TAPS) && (ai % 4 == 0);
    endfunction

    function automatic logic [3:0] eff_strb(input logic [3:0] s);
`ifdef FIR_TAP_WSTRB_EN
        return s;
`else
        return 4'hF;
`endif
    endfunction

    function automatic logic [31:0] apply_strb(input logic [31:0] old_w, input logic [31:0] new_w,
                                               input logic [3:0] s);
        logic [31:0] mask;
        mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        return (old_w & ~mask) | (new_w & mask);
    endfunction

    function automatic void model_reset();
        mdl_len   = 32'd0;
        mdl_start = 1'b0;
        mdl_done  = 1'b0;
        exp_q.delete();
    endfunction

    function automatic void model_write(input logic [ADDR_W-1:0] a, input logic [31:0] d,
                                        input logic [3:0] s);
        logic [3:0] m;
        m = eff_strb(s);
        if (a == 12'h000) begin
            if (m[0] && d[0] && !mdl_start && !core_busy) mdl_start = 1'b1;
        end else if (a == 12'h010) begin
            if (!core_busy) mdl_len = apply_strb(mdl_len, d, m);
        end else if (is_tap_addr(a) && !core_busy) begin
            mdl_tap[(int'(a) - 32) / 4] = apply_strb(mdl_tap[(int'(a) - 32) / 4], d, m);
        end
    endfunction

    function automatic logic [31:0] model_read(input logic [ADDR_W-1:0] a);
        logic idle;
        idle = !mdl_start && !core_busy;
        if (a == 12'h000) return {29'd0, idle, mdl_done, mdl_start};
        if (a == 12'h010) return mdl_len;
        if (is_tap_addr(a)) return core_busy ? 32'hFFFF_FFFF : mdl_tap[(int'(a) - 32) / 4];
        return 32'h0;
    endfunction

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (!axis_rst) begin
            if (rvalid && rready) begin
                if (exp_q.size() == 0) check("rdata_unexpected", 32'(rvalid), 32'd0);
                else check("rdata", rdata, exp_q.pop_front());
            end
            check("data_length", data_length, mdl_len);
            check("ap_start_o", 32'(ap_start_o), 32'(mdl_start));
            if (!core_busy && !awready && !arready)
                check("tap_quiet", {27'd0, tap_EN, tap_WE}, 32'd0);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic axi_write(input logic [ADDR_W-1:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic en, output logic [3:0] we,
                             output logic [ADDR_W-1:0] ta, output logic [31:0] di);
        int n;
        bit seen;
        @(posedge clk); #1;
        awvalid = 1'b1; wvalid = 1'b1; awaddr = a; wdata = d; wstrb = s;
        seen = 1'b0; n = 0; en = 1'b0; we = 4'h0; ta = '0; di = '0;
        while (!seen && n < 20) begin
            @(negedge clk);
            if (awready && wready) begin
                seen = 1'b1; en = tap_EN; we = tap_WE; ta = tap_A; di = tap_Di;
            end
            @(posedge clk);
            n++;
        end
        check("aw_handshake", 32'(seen), 32'd1);
        if (seen) model_write(a, d, s);
        #1;
        awvalid = 1'b0; wvalid = 1'b0;
    endtask

    task automatic read_wait(input int hold, input bit done_at_hs,
                             output logic [31:0] d, output int lat, output bit ok);
        bit got_ar;
        logic [31:0] first;
        got_ar = 1'b0; ok = 1'b0; lat = 0; d = '0;
        while (!ok && lat < 20) begin
            @(negedge clk);
            if (rvalid) ok = 1'b1;
            else begin
                if (arready) got_ar = 1'b1;
                @(posedge clk);
                lat++;
                #1;
                if (got_ar) arvalid = 1'b0;
            end
        end
        check("rvalid_seen", 32'(ok), 32'd1);
        if (!ok) begin
            arvalid = 1'b0;
            exp_q.delete();
            return;
        end
        first = rdata;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("rdata_hold", rdata, first);
            check("rvalid_hold", 32'(rvalid), 32'd1);
        end
        @(posedge clk); #1;
        rready = 1'b1;
        if (done_at_hs) core_done = 1'b1;
        @(negedge clk);
        d = rdata;
        @(posedge clk); #1;
        rready = 1'b0; core_done = 1'b0;
    endtask

    task automatic axi_read(input logic [ADDR_W-1:0] a, input int hold, input bit done_at_hs,
                            output logic [31:0] d, output int lat);
        bit ok;
        @(posedge clk); #1;
        exp_q.push_back(model_read(a));
        arvalid = 1'b1; araddr = a;
        read_wait(hold, done_at_hs, d, lat, ok);
        if (ok) begin
            if (done_at_hs) mdl_done = 1'b1;
            else if (a == 12'h000) mdl_done = 1'b0;
        end
    endtask

    // ---------------- directed sequence ----------------
    logic              w_en;
    logic [3:0]        w_we;
    logic [ADDR_W-1:0] w_ta;
    logic [31:0]       w_di;
    logic [31:0]       rd;
    int                lat;
    bit                ok, seen, ar_early;
    int                n;

    initial begin
        awvalid = 0; wvalid = 0; arvalid = 0; rready = 0;
        awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
        core_tap_A = '0; core_busy = 0; core_done = 0;
        for (int i = 0; i < NUM_TAPS; i++) mdl_tap[i] = 32'd0;
        model_reset();
        axis_rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", {29'd0, awready, wready, arready}, 32'd0);
        check("rst_rvalid", 32'(rvalid), 32'd0);
        check("rst_ap_start", 32'(ap_start_o), 32'd0);
        check("rst_tap_ctl", {27'd0, tap_EN, tap_WE}, 32'd0);
        check("rst_tap_A", 32'(tap_A), 32'd0);
        check("rst_tap_Di", tap_Di, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_len", data_length, 32'd0);
        @(posedge clk); #1;
        axis_rst = 1'b0;

        axi_read(12'h000, 0, 0, rd, lat);
        check("ctrl_after_rst", rd, 32'h4);

        // single tap write strobes
        axi_write(12'h020, 32'h0000_000A, 4'hF, w_en, w_we, w_ta, w_di);
        check("wr_tap_EN", 32'(w_en), 32'd1);
        check("wr_tap_WE", 32'(w_we), 32'hF);
        check("wr_tap_A", 32'(w_ta), 32'h000);
        check("wr_tap_Di", w_di, 32'h0000_000A);

        for (int i = 0; i < NUM_TAPS; i++)
            axi_write(ADDR_W'(32 + 4 * i), 32'(i + 1), 4'hF, w_en, w_we, w_ta, w_di);
        check("last_tap_A", 32'(w_ta), 32'h028);
        axi_read(12'h048, 5, 0, rd, lat);
        check("tap10_value", rd, 32'h0000_000B);
        check("read_latency", 32'(lat), 32'd3);
        axi_read(12'h044, 0, 0, rd, lat);
        check("tap9_value", rd, 32'h0000_000A);
        axi_read(12'h020, 0, 0, rd, lat);
        check("tap0_value", rd, 32'h0000_0001);

        // simultaneous write and read to the same tap: write is served first
        @(posedge clk); #1;
        awvalid = 1; wvalid = 1; awaddr = 12'h024; wdata = 32'h55; wstrb = 4'hF;
        arvalid = 1; araddr = 12'h024;
        seen = 0; ar_early = 0; n = 0;
        while (!seen && n < 20) begin
            @(negedge clk);
            if (awready) seen = 1;
            if (arready) ar_early = 1;
            @(posedge clk);
            n++;
        end
        check("sim_write_first", 32'(seen && !ar_early), 32'd1);
        model_write(12'h024, 32'h55, 4'hF);
        exp_q.push_back(model_read(12'h024));
        #1;
        awvalid = 0; wvalid = 0;
        read_wait(0, 0, rd, lat, ok);
        check("sim_read", rd, 32'h0000_0055);

        axi_write(12'h010, 32'd100, 4'hF, w_en, w_we, w_ta, w_di);
        check("len_no_bram", 32'(w_en), 32'd0);
        axi_read(12'h010, 0, 0, rd, lat);
        check("len_read", rd, 32'd100);

        // start / busy / done
        axi_write(12'h000, 32'h1, 4'hF, w_en, w_we, w_ta, w_di);
        @(negedge clk);
        check("start_set", 32'(ap_start_o), 32'd1);
        axi_read(12'h000, 0, 0, rd, lat);
        check("ctrl_started", rd, 32'h1);
        @(posedge clk); #1;
        core_busy = 1; core_tap_A = 12'h014;
        @(negedge clk);
        check("start_before_busy_sampled", 32'(ap_start_o), 32'd1);
        check("core_tap_A", 32'(tap_A), 32'h014);
        check("core_tap_ctl", {27'd0, tap_EN, tap_WE}, 32'h10);
        @(posedge clk);
        mdl_start = 1'b0;
        @(negedge clk);
        check("start_cleared", 32'(ap_start_o), 32'd0);
        core_tap_A = 12'h008;
        axi_read(12'h028, 0, 0, rd, lat);
        check("busy_tap_read", rd, 32'hFFFF_FFFF);
        axi_write(12'h020, 32'h99, 4'hF, w_en, w_we, w_ta, w_di);
        check("busy_tap_WE", 32'(w_we), 32'd0);
        check("busy_tap_A", 32'(w_ta), 32'h008);
        axi_write(12'h010, 32'd7, 4'hF, w_en, w_we, w_ta, w_di);
        axi_read(12'h010, 0, 0, rd, lat);
        check("busy_len_kept", rd, 32'd100);
        axi_write(12'h000, 32'h1, 4'hF, w_en, w_we, w_ta, w_di);
        @(posedge clk); #1; core_done = 1;
        @(posedge clk); #1; core_done = 0;
        mdl_done = 1'b1;
        axi_read(12'h000, 0, 0, rd, lat);
        check("ctrl_done_busy", rd, 32'h2);
        @(posedge clk); #1; core_busy = 0;
        axi_read(12'h000, 0, 0, rd, lat);
        check("ctrl_idle", rd, 32'h4);
        axi_read(12'h020, 0, 0, rd, lat);
        check("tap0_not_overwritten", rd, 32'h1);
        axi_read(12'h000, 0, 1, rd, lat);
        axi_read(12'h000, 0, 0, rd, lat);
        check("done_set_wins", rd, 32'h6);
        axi_read(12'h000, 0, 0, rd, lat);
        check("done_cleared", rd, 32'h4);

        // byte strobes
        axi_write(12'h020, 32'h1122_3344, 4'hF, w_en, w_we, w_ta, w_di);
        axi_write(12'h020, 32'hAABB_CCDD, 4'h3, w_en, w_we, w_ta, w_di);
        axi_read(12'h020, 0, 0, rd, lat);
`ifdef FIR_TAP_WSTRB_EN
        check("strb_WE", 32'(w_we), 32'h3);
        check("strb_read", rd, 32'h1122_CCDD);
`else
        check("strb_WE", 32'(w_we), 32'hF);
        check("strb_read", rd, 32'hAABB_CCDD);
`endif

        // out-of-range
        axi_write(12'h060, 32'h123, 4'hF, w_en, w_we, w_ta, w_di);
        check("oor_no_bram", 32'(w_en), 32'd0);
        axi_read(12'h060, 0, 0, rd, lat);
        check("oor_read", rd, 32'h0);
        axi_read(12'h044, 0, 0, rd, lat);
        check("tap9_again", rd, 32'hA);

        // reset during RD_WAIT
        @(posedge clk); #1;
        arvalid = 1; araddr = 12'h044;
        seen = 0; n = 0;
        while (!seen && n < 20) begin
            @(negedge clk);
            if (arready) seen = 1;
            @(posedge clk);
            n++;
        end
        check("abort_ar_seen", 32'(seen), 32'd1);
        #1;
        arvalid = 0; axis_rst = 1; model_reset();
        @(posedge clk); #1;
        axis_rst = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("abort_no_rvalid", 32'(rvalid), 32'd0);
        end
        check("abort_rdata_rst", rdata, 32'd0);
        axi_read(12'h000, 0, 0, rd, lat);
        check("abort_then_read", rd, 32'h4);
        check("abort_read_latency", 32'(lat), 32'd3);

        // reset during WR: BRAM must not be written
        @(posedge clk); #1;
        awvalid = 1; wvalid = 1; awaddr = 12'h024; wdata = 32'hDEAD; wstrb = 4'hF;
        @(posedge clk); #1;
        axis_rst = 1; model_reset();
        @(negedge clk);
        check("rst_wr_no_WE", {27'd0, tap_EN, tap_WE}, 32'd0);
        @(posedge clk); #1;
        axis_rst = 0; awvalid = 0; wvalid = 0;
        axi_read(12'h024, 0, 0, rd, lat);
        check("rst_wr_tap_kept", rd, 32'h55);
        axi_read(12'h010, 0, 0, rd, lat);
        check("rst_len_cleared", rd, 32'd0);

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
